// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save packet accumulator (in_valid/in_ready/in_last/in_mask/num1-3 in; out_valid/out_ready/result/beat_count/overflow out)
module csa_stream_accumulator #(
  parameter int N = 8,
  parameter int MAX_BEATS = 16,
  localparam int W = N + 2 + $clog2(MAX_BEATS),
  localparam int CW = $clog2(MAX_BEATS + 1) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_mask,
  input  logic [N-1:0]  num1,
  input  logic [N-1:0]  num2,
  input  logic [N-1:0]  num3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic [CW-1:0] beat_count,
  output logic          overflow
);
  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] s_q, s_d, c_q, c_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d, bc_q, bc_d, cnt_inc;
  logic ovf_q, ovf_d, ovo_q, ovo_d, accept;
  logic [W-1:0] a1, a2, a3, s1, c1, s2, c2, s3, c3;
  always_comb begin
    accept = in_valid && state_q == ACCUM;
    a1 = in_mask[0] ? W'(num1) : '0;
    a2 = in_mask[1] ? W'(num2) : '0;
    a3 = in_mask[2] ? W'(num3) : '0;
    s1 = s_q ^ c_q ^ a1;
    c1 = ((s_q & c_q) | (s_q & a1) | (c_q & a1)) << 1;
    s2 = s1 ^ c1 ^ a2;
    c2 = ((s1 & c1) | (s1 & a2) | (c1 & a2)) << 1;
    s3 = s2 ^ c2 ^ a3;
    c3 = ((s2 & c2) | (s2 & a3) | (c2 & a3)) << 1;
    cnt_inc = cnt_q + CW'(cnt_q != '1);
    state_d = state_q;
    s_d = s_q;
    c_d = c_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    res_d = res_q;
    bc_d = bc_q;
    ovo_d = ovo_q;
    if (accept) begin
      s_d = s3;
      c_d = c3;
      cnt_d = cnt_inc;
      ovf_d = ovf_q | (cnt_inc > CW'(MAX_BEATS));
      state_d = in_last ? RESOLVE : ACCUM;
    end
    if (state_q == RESOLVE) begin
      res_d = s_q + c_q;
      bc_d = cnt_q;
      ovo_d = ovf_q;
      state_d = DONE;
    end
    if (state_q == DONE && out_ready) begin
      state_d = ACCUM;
      s_d = '0;
      c_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q <= '0;
      c_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      res_q <= '0;
      bc_q <= '0;
      ovo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
      bc_q <= bc_d;
      ovo_q <= ovo_d;
    end
  end
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign result = res_q;
  assign beat_count = bc_q;
  assign overflow = ovo_q;
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: table-driven and directed checks of csa_stream_accumulator
module tb_csa_stream_accumulator;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [2:0] in_mask = '0;
  logic [7:0] num1 = '0, num2 = '0, num3 = '0;
  logic in_ready, out_valid, overflow;
  logic [13:0] result;
  logic [5:0] beat_count;
  int total = 0, bad = 0;
  typedef struct {
    logic [7:0] a, b, c;
    logic [2:0] m;
    logic l;
    int r, bc, ov;
    string nm;
  } vec_t;
  vec_t vq[$];
  csa_stream_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_mask(in_mask), .num1(num1), .num2(num2), .num3(num3),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .beat_count(beat_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] a, b, c, input logic [2:0] m, input logic l,
                     input int r, bc, ov, input string nm);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.m = m; v.l = l; v.r = r; v.bc = bc; v.ov = ov; v.nm = nm;
    vq.push_back(v);
  endtask
  task automatic beat(input logic [7:0] a, b, c, input logic [2:0] m, input logic l, input string nm);
    num1 = a; num2 = b; num3 = c; in_mask = m; in_last = l; in_valid = 1;
    chk({nm, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask
  task automatic finish_pkt(input int r, bc, ov, input string nm);
    chk({nm, " resolve out_valid"}, out_valid, 0);
    chk({nm, " resolve in_ready"}, in_ready, 0);
    @(posedge clk); #1;
    chk({nm, " out_valid"}, out_valid, 1);
    chk({nm, " in_ready in done"}, in_ready, 0);
    chk({nm, " result"}, result, r);
    chk({nm, " beat_count"}, beat_count, bc);
    chk({nm, " overflow"}, overflow, ov);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({nm, " in_ready after"}, in_ready, 1);
      chk({nm, " out_valid after"}, out_valid, 0);
    end
  endtask
  initial begin
    add(8'hFF, 8'hFF, 8'hFF, 3'b111, 1, 765, 1, 0, "single");
    for (int i = 1; i <= 16; i++) add(8'hFF, 8'hFF, 8'hFF, 3'b111, i == 16, 12240, 16, 0, "full16");
    add(8'h0F, 8'hF0, 8'h66, 3'b101, 0, 0, 0, 0, "masked");
    add(8'h0F, 8'h0F, 8'h66, 3'b010, 1, 132, 2, 0, "masked");
    for (int i = 1; i <= 22; i++) add(8'hFF, 8'hFF, 8'hFF, 3'b111, i == 22, 446, 22, 1, "ovf22");
    add(8'd1, 8'd2, 8'd3, 3'b111, 1, 6, 1, 0, "after_ovf");
    add(8'd5, 8'd6, 8'd7, 3'b000, 1, 0, 1, 0, "mask000");
    add(8'd10, 8'd20, 8'd30, 3'b110, 0, 0, 0, 0, "mixed");
    add(8'd40, 8'd50, 8'd60, 3'b011, 1, 140, 2, 0, "mixed");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("reset result", result, 0);
    chk("reset beat_count", beat_count, 0);
    chk("reset overflow", overflow, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    for (int i = 0; i < vq.size(); i++) begin
      beat(vq[i].a, vq[i].b, vq[i].c, vq[i].m, vq[i].l, vq[i].nm);
      if (vq[i].l) finish_pkt(vq[i].r, vq[i].bc, vq[i].ov, vq[i].nm);
    end
    out_ready = 0;
    beat(8'd1, 8'd2, 8'd3, 3'b111, 1, "bp");
    finish_pkt(6, 1, 0, "bp");
    for (int i = 0; i < 3; i++) begin
      num1 = 8'hAA; num2 = 8'h55; num3 = 8'h33; in_mask = 3'b111; in_valid = 1; in_last = 0;
      @(posedge clk); #1;
      chk("bp hold out_valid", out_valid, 1);
      chk("bp hold result", result, 6);
      chk("bp hold in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);
    beat(8'd0, 8'd0, 8'd1, 3'b111, 1, "bp_next");
    finish_pkt(1, 1, 0, "bp_next");
    for (int i = 0; i < 3; i++) beat(8'hFF, 8'hFF, 8'hFF, 3'b111, 0, "midrst");
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    beat(8'd1, 8'd2, 8'd3, 3'b111, 1, "midrst_pkt");
    finish_pkt(6, 1, 0, "midrst_pkt");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
